cache_line_bridge: RTL and testbench

Memory-side adapter directly downstream of the 4-way/4-word cache. It accepts 128-bit line reads and writes from the cache master port and serialises them into four 32-bit word accesses on a single-port synchronous word RAM. Read beats are reassembled into a 128-bit line before being returned to the cache. The block is the only agent between the cache refill/write-back path and backing RAM.

---
 rtl/cache_bridge_pkg.sv | 17 +
 rtl/rd_lat_pipe.sv | 38 +++
 rtl/cache_line_bridge.sv | 143 ++++++++++++++
 tb/tb_cache_line_bridge.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_bridge_pkg.sv
// rtl/cache_bridge_pkg.sv - shared constants and FSM encoding for cache_line_bridge
package cache_bridge_pkg;

  localparam int BEATS  = 4;
  localparam int WORD_W = 32;
  localparam int LINE_W = 128;
  localparam int TAG_W  = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BEAT  = 3'd1,
    RD_ISSUE = 3'd2,
    RD_DRAIN = 3'd3,
    RESP     = 3'd4
  } state_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// rtl/rd_lat_pipe.sv - RD_LAT-deep {valid, beat} tag pipe aligning RAM read returns
module rd_lat_pipe
  import cache_bridge_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [RD_LAT-1:0] vld_q;
  logic [TAG_W-1:0]  tag_q [RD_LAT];

  // Shift the issue tag along so it emerges in the same cycle as its read word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      tag_q[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_tag   = tag_q[RD_LAT-1];

endmodule

// File: rtl/cache_line_bridge.sv
// rtl/cache_line_bridge.sv - 128-bit cache line to 4x32-bit word RAM bridge; CACHE_BRIDGE_STATS_EN builds the accept counters
module cache_line_bridge
  import cache_bridge_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int LINE_AW = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LINE_AW-1:0]   i_c_addr,
  input  logic [LINE_W-1:0]    i_c_writedata,
  input  logic                 i_c_read,
  input  logic                 i_c_write,
  output logic [LINE_W-1:0]    o_c_readdata,
  output logic                 o_c_readdata_valid,
  output logic                 o_c_waitrequest,
  output logic                 o_r_en,
  output logic                 o_r_we,
  output logic [LINE_AW+1:0]   o_r_addr,
  output logic [WORD_W-1:0]    o_r_wdata,
  input  logic [WORD_W-1:0]    i_r_rdata,
  output logic [31:0]          o_cnt_rd,
  output logic [31:0]          o_cnt_wr
);

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    beat_q;
  logic [LINE_AW-1:0]  addr_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   asm_q, asm_d;
  logic [LINE_W-1:0]   rdata_q;
  logic                accept_wr, accept_rd;
  logic                ret_valid;
  logic [TAG_W-1:0]    ret_tag;

  rd_lat_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_lat_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (state_q == RD_ISSUE),
    .in_tag   (beat_q),
    .out_valid(ret_valid),
    .out_tag  (ret_tag)
  );

  // Next state, accept decisions and RAM strobes decoded from the registered state/beat.
  always_comb begin
    state_d   = state_q;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    o_r_en    = 1'b0;
    o_r_we    = 1'b0;
    o_r_addr  = '0;
    o_r_wdata = '0;
    case (state_q)
      IDLE: begin
        // Write has priority; a concurrent read stays held by the cache.
        if (i_c_write) begin
          accept_wr = 1'b1;
          state_d   = WR_BEAT;
        end else if (i_c_read) begin
          accept_rd = 1'b1;
          state_d   = RD_ISSUE;
        end
      end
      WR_BEAT: begin
        o_r_en    = 1'b1;
        o_r_we    = 1'b1;
        o_r_addr  = {addr_q, beat_q};
        o_r_wdata = line_q[beat_q*WORD_W +: WORD_W];
        if (beat_q == 2'd3) state_d = IDLE;
      end
      RD_ISSUE: begin
        o_r_en   = 1'b1;
        o_r_addr = {addr_q, beat_q};
        if (beat_q == 2'd3) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        // Beat 3 is issued last, so its return marks a complete line.
        if (ret_valid && ret_tag == 2'd3) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Merge a returning word into the assembly line.
  always_comb begin
    asm_d = asm_q;
    if (ret_valid) asm_d[ret_tag*WORD_W +: WORD_W] = i_r_rdata;
  end

  // State, beat counter, request latches and the line registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_wr || accept_rd) begin
        beat_q <= '0;
        addr_q <= i_c_addr;
      end else if (state_q == WR_BEAT || state_q == RD_ISSUE) begin
        beat_q <= beat_q + 2'd1;
      end
      if (accept_wr) line_q <= i_c_writedata;
      asm_q <= asm_d;
      // The visible read line only changes on entry to RESP.
      if (state_q == RD_DRAIN && state_d == RESP) rdata_q <= asm_d;
    end
  end

  assign o_c_waitrequest    = (state_q != IDLE);
  assign o_c_readdata_valid = (state_q == RESP);
  assign o_c_readdata       = rdata_q;

`ifdef CACHE_BRIDGE_STATS_EN
  logic [31:0] cnt_rd_q, cnt_wr_q;

  // Accepted-transaction counters, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_rd_q <= '0;
      cnt_wr_q <= '0;
    end else begin
      if (accept_rd) cnt_rd_q <= cnt_rd_q + 32'd1;
      if (accept_wr) cnt_wr_q <= cnt_wr_q + 32'd1;
    end
  end

  assign o_cnt_rd = cnt_rd_q;
  assign o_cnt_wr = cnt_wr_q;
`else
  assign o_cnt_rd = '0;
  assign o_cnt_wr = '0;
`endif

endmodule

// File: tb/tb_cache_line_bridge.sv
// tb/tb_cache_line_bridge.sv - directed self-checking bench for cache_line_bridge at RD_LAT 1 and 4
module tb_cache_line_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         sel;
  logic [25:0]  c_addr;
  logic [127:0] c_wdata;
  logic         c_read, c_write;

  logic         c_read0, c_write0, c_read1, c_write1;
  logic [127:0] rdata0, rdata1;
  logic         valid0, valid1, wait0, wait1, en0, en1, we0, we1;
  logic [27:0]  raddr0, raddr1;
  logic [31:0]  wdata0, wdata1, rrd0, rrd1;
  logic [31:0]  cntr0, cntw0, cntr1, cntw1;

  assign c_read0  = c_read  & ~sel;
  assign c_write0 = c_write & ~sel;
  assign c_read1  = c_read  & sel;
  assign c_write1 = c_write & sel;

  cache_line_bridge #(.RD_LAT(1), .LINE_AW(26)) u_dut0 (
    .clk(clk), .rst(rst), .i_c_addr(c_addr), .i_c_writedata(c_wdata),
    .i_c_read(c_read0), .i_c_write(c_write0), .o_c_readdata(rdata0),
    .o_c_readdata_valid(valid0), .o_c_waitrequest(wait0), .o_r_en(en0),
    .o_r_we(we0), .o_r_addr(raddr0), .o_r_wdata(wdata0), .i_r_rdata(rrd0),
    .o_cnt_rd(cntr0), .o_cnt_wr(cntw0)
  );

  cache_line_bridge #(.RD_LAT(4), .LINE_AW(26)) u_dut1 (
    .clk(clk), .rst(rst), .i_c_addr(c_addr), .i_c_writedata(c_wdata),
    .i_c_read(c_read1), .i_c_write(c_write1), .o_c_readdata(rdata1),
    .o_c_readdata_valid(valid1), .o_c_waitrequest(wait1), .o_r_en(en1),
    .o_r_we(we1), .o_r_addr(raddr1), .o_r_wdata(wdata1), .i_r_rdata(rrd1),
    .o_cnt_rd(cntr1), .o_cnt_wr(cntw1)
  );

  // Word RAM models: latency 1 for dut0, latency 4 for dut1.
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] rq1  [4];
  always @(posedge clk) begin
    if (en0 && we0) mem0[raddr0[7:0]] <= wdata0;
    rrd0 <= mem0[raddr0[7:0]];
  end
  always @(posedge clk) begin
    if (en1 && we1) mem1[raddr1[7:0]] <= wdata1;
    rq1[0] <= mem1[raddr1[7:0]];
    rq1[1] <= rq1[0];
    rq1[2] <= rq1[1];
    rq1[3] <= rq1[2];
  end
  assign rrd1 = rq1[3];

  logic [127:0] s_rdata;
  logic         s_valid, s_wait, s_en, s_we;
  logic [27:0]  s_addr;
  logic [31:0]  s_wdata;
  assign s_rdata = sel ? rdata1 : rdata0;
  assign s_valid = sel ? valid1 : valid0;
  assign s_wait  = sel ? wait1  : wait0;
  assign s_en    = sel ? en1    : en0;
  assign s_we    = sel ? we1    : we0;
  assign s_addr  = sel ? raddr1 : raddr0;
  assign s_wdata = sel ? wdata1 : wdata0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wait"},  s_wait,  1'b0);
    chk({tag, "_valid"}, s_valid, 1'b0);
    chk({tag, "_rdata"}, s_rdata, 128'h0);
    chk({tag, "_en"},    s_en,    1'b0);
    chk({tag, "_we"},    s_we,    1'b0);
    chk({tag, "_addr"},  s_addr,  28'h0);
    chk({tag, "_wdata"}, s_wdata, 32'h0);
  endtask

  task automatic do_write(input logic [25:0] a, input logic [127:0] line, input string tag);
    @(negedge clk);
    c_addr  = a;
    c_wdata = line;
    c_write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      c_write = 1'b0;
      chk({tag, "_wait"},  s_wait,  1'b1);
      chk({tag, "_en"},    s_en,    1'b1);
      chk({tag, "_we"},    s_we,    1'b1);
      chk({tag, "_addr"},  s_addr,  {a, k[1:0]});
      chk({tag, "_wdata"}, s_wdata, line[k*32 +: 32]);
    end
    @(negedge clk);
    chk({tag, "_wait_done"}, s_wait, 1'b0);
  endtask

  task automatic do_read(input logic [25:0] a, input logic [127:0] exp, input int lat, input string tag);
    int vcnt = 0;
    int vcyc = 0;
    @(negedge clk);
    c_addr = a;
    c_read = 1'b1;
    for (int k = 1; k <= lat + 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        c_read = 1'b0;
        chk({tag, "_wait_first"}, s_wait, 1'b1);
      end
      if (s_valid) begin
        vcnt++;
        if (vcyc == 0) vcyc = k;
        chk({tag, "_data"}, s_rdata, exp);
      end
      if (k == lat + 5) chk({tag, "_wait_resp"}, s_wait, 1'b1);
      if (k == lat + 6) chk({tag, "_wait_after"}, s_wait, 1'b0);
    end
    chk({tag, "_pulses"}, vcnt, 1);
    chk({tag, "_valid_cycle"}, vcyc, lat + 5);
  endtask

  localparam logic [127:0] LINE5 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  localparam logic [127:0] LINE9 = {32'h90000004, 32'h90000003, 32'h90000002, 32'h90000001};
  localparam logic [127:0] LINE3 = {32'h33330004, 32'h33330003, 32'h33330002, 32'h33330001};

  initial begin
    int vcnt;
    int vpos [3];
    int exp_wr, exp_rd;
    logic [127:0] line;

    rst = 1'b0; sel = 1'b0; c_addr = '0; c_wdata = '0; c_read = 1'b0; c_write = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst0");
    sel = 1'b1;
    #1;
    chk_idle_outputs("rst1");
    sel = 1'b0;
    rst = 1'b1;

    // Write then read back at RD_LAT=1.
    do_write(26'h5, LINE5, "wr5");
    chk("mem14", mem0[8'h14], 32'hAAAA0000);
    chk("mem17", mem0[8'h17], 32'hDDDD0003);
    do_read(26'h5, LINE5, 1, "rd5");

    // Simultaneous write and read of line 9: write first, read follows.
    @(negedge clk);
    c_addr = 26'h9; c_wdata = LINE9; c_write = 1'b1; c_read = 1'b1;
    vcnt = 0; vpos[0] = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        c_write = 1'b0;
        chk("sim_we_first", s_we, 1'b1);
      end
      if (k == 6) c_read = 1'b0;
      if (s_valid) begin
        vcnt++;
        vpos[0] = k;
        chk("sim_data", s_rdata, LINE9);
      end
    end
    chk("sim_pulses", vcnt, 1);
    chk("sim_valid_cycle", vpos[0], 11);

    // RD_LAT=4 instance: write then read line 3.
    sel = 1'b1;
    do_write(26'h3, LINE3, "wr3_l4");
    do_read(26'h3, LINE3, 4, "rd3_l4");
    sel = 1'b0;

    // Back-to-back held reads on the RD_LAT=1 instance.
    @(negedge clk);
    c_addr = 26'h5; c_read = 1'b1;
    vcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (s_valid) begin
        if (vcnt < 3) vpos[vcnt] = k;
        vcnt++;
        if (vcnt == 3) c_read = 1'b0;
      end
    end
    c_read = 1'b0;
    chk("b2b_pulses", vcnt, 3);
    chk("b2b_first", vpos[0], 6);
    chk("b2b_gap1", vpos[1] - vpos[0], 7);
    chk("b2b_gap2", vpos[2] - vpos[1], 7);

    // Reset during the second read issue beat.
    @(negedge clk);
    c_addr = 26'h5; c_read = 1'b1;
    @(negedge clk);
    c_read = 1'b0;
    @(negedge clk);
    chk("abort_beat1_addr", s_addr, {26'h5, 2'd1});
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("abort");
    rst = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (s_valid) vcnt++;
    end
    chk("abort_no_pulse", vcnt, 0);
    do_read(26'h5, LINE5, 1, "rd_after_rst");

    // Counters from a fresh reset: 7 writes and 5 reads.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("cnt_rst_rd", cntr0, 32'd0);
    for (int i = 0; i < 7; i++) begin
      line = {4{32'h11110000 + 32'(i)}};
      do_write(26'h20, line, "cnt_wr");
    end
    for (int i = 0; i < 5; i++) begin
      do_read(26'h20, {4{32'h11110006}}, 1, "cnt_rd");
    end
`ifdef CACHE_BRIDGE_STATS_EN
    exp_wr = 7; exp_rd = 5;
`else
    exp_wr = 0; exp_rd = 0;
`endif
    chk("cnt_wr", cntw0, exp_wr);
    chk("cnt_rd", cntr0, exp_rd);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
